// File: rtl/double_ask_rx_demod.sv
// Non-coherent 2ASK receiver: rectify, integrate per bit window, slice
// against an energy threshold and reassemble MSB-first words. Bit timing
// is open-loop, referenced to reset release plus ALIGN_DLY cycles.
module double_ask_rx_demod #(
  parameter int SAMPLE_W   = 16,
  parameter int BIT_CYCLES = 50,
  parameter int WORD_BITS  = 16,
  parameter int ALIGN_DLY  = 0,
  parameter int THRESH     = 500000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic signed [SAMPLE_W-1:0] rx_in,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic [WORD_BITS-1:0]       data_out,
  output logic                       data_valid,
  output logic                       aligned
);

  localparam int ACC_W = SAMPLE_W + 1 + $clog2(BIT_CYCLES);
  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int NB_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int AL_W  = (ALIGN_DLY > 1) ? $clog2(ALIGN_DLY) : 1;

  localparam logic [0:0] S_ALIGN = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [0:0] S_INIT  = (ALIGN_DLY == 0) ? S_RUN : S_ALIGN;

  localparam logic [ACC_W:0]     THR      = (ACC_W + 1)'(THRESH);
  localparam logic [CYC_W-1:0]   CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [NB_W-1:0]    NB_LAST  = NB_W'(WORD_BITS - 1);
  localparam logic [AL_W-1:0]    AL_LAST  = AL_W'((ALIGN_DLY > 0) ? ALIGN_DLY - 1 : 0);

  logic [0:0]           state_q, state_d;
  logic [AL_W-1:0]      al_cnt_q, al_cnt_d;
  logic                 aligned_q, aligned_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [NB_W-1:0]      nbit_q, nbit_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic                 bit_q, bit_d;
  logic                 bit_vld_q, bit_vld_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic                 data_vld_q, data_vld_d;

  logic [SAMPLE_W:0]    rx_ext;
  logic [SAMPLE_W:0]    abs_s;
  logic [ACC_W-1:0]     sum_s;
  logic                 dec_s;
  logic [WORD_BITS-1:0] word_s;

  // Rectify at one extra bit so the most negative sample maps without overflow.
  always_comb begin
    rx_ext = {rx_in[SAMPLE_W-1], rx_in};
    abs_s  = rx_in[SAMPLE_W-1] ? ('0 - rx_ext) : rx_ext;
    sum_s  = acc_q + ACC_W'(abs_s);
    dec_s  = ({1'b0, sum_s} > THR);
    word_s = {shreg_q[WORD_BITS-2:0], dec_s};
  end

  // Alignment FSM: count off ALIGN_DLY cycles, then stay in RUN.
  always_comb begin
    state_d   = state_q;
    al_cnt_d  = al_cnt_q;
    aligned_d = (state_q == S_RUN);
    case (state_q)
      S_ALIGN: begin
        if (al_cnt_q == AL_LAST) state_d = S_RUN;
        else                     al_cnt_d = al_cnt_q + AL_W'(1);
      end
      default: state_d = S_RUN;
    endcase
  end

  // Window integration, bit slicing and word assembly once aligned.
  always_comb begin
    cyc_d      = cyc_q;
    nbit_d     = nbit_q;
    acc_d      = acc_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    bit_vld_d  = 1'b0;
    data_d     = data_q;
    data_vld_d = 1'b0;
    if (aligned_q) begin
      if (cyc_q == CYC_LAST) begin
        cyc_d     = '0;
        acc_d     = '0;
        bit_d     = dec_s;
        bit_vld_d = 1'b1;
        shreg_d   = word_s;
        if (nbit_q == NB_LAST) begin
          nbit_d     = '0;
          data_d     = word_s;
          data_vld_d = 1'b1;
        end else begin
          nbit_d = nbit_q + NB_W'(1);
        end
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
        acc_d = sum_s;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_INIT;
      al_cnt_q   <= '0;
      aligned_q  <= 1'b0;
      cyc_q      <= '0;
      nbit_q     <= '0;
      acc_q      <= '0;
      shreg_q    <= '0;
      bit_q      <= 1'b0;
      bit_vld_q  <= 1'b0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      al_cnt_q   <= al_cnt_d;
      aligned_q  <= aligned_d;
      cyc_q      <= cyc_d;
      nbit_q     <= nbit_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      bit_vld_q  <= bit_vld_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = bit_vld_q;
  assign data_out   = data_q;
  assign data_valid = data_vld_q;
  assign aligned    = aligned_q;

endmodule

// File: tb/tb_double_ask_rx_demod.sv
// Bench for double_ask_rx_demod: two instances (ALIGN_DLY 0 and 3) share
// the stimulus; expectations come from per-window energy sums over cycles.
module tb_double_ask_rx_demod;

  localparam int THR = 500000;
  localparam int DLY [2] = '{0, 3};

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] rx_in = '0;
  logic               bo [2];
  logic               bv [2];
  logic               dv [2];
  logic               al [2];
  logic [15:0]        dout [2];

  int n_vec = 0;
  int n_err = 0;

  int          sums  [2][64];
  bit          bits  [2][64];
  bit          e_bit [2];
  logic [15:0] e_data [2];
  logic [15:0] wtab [3] = '{16'hFEC8, 16'h0137, 16'hF0F0};

  always #10 clk = ~clk;

  double_ask_rx_demod #(.ALIGN_DLY(0)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx_in(rx_in),
    .bit_out(bo[0]), .bit_valid(bv[0]), .data_out(dout[0]),
    .data_valid(dv[0]), .aligned(al[0])
  );

  double_ask_rx_demod #(.ALIGN_DLY(3)) dut3 (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx_in(rx_in),
    .bit_out(bo[1]), .bit_valid(bv[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .aligned(al[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string where);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.d%0d.bit_out", where, d), 32'(bo[d]), 0);
      check($sformatf("%s.d%0d.bit_valid", where, d), 32'(bv[d]), 0);
      check($sformatf("%s.d%0d.data_out", where, d), 32'(dout[d]), 0);
      check($sformatf("%s.d%0d.data_valid", where, d), 32'(dv[d]), 0);
      check($sformatf("%s.d%0d.aligned", where, d), 32'(al[d]), 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode: 0 zero, 1 +20000, 2 -20000, 3 word pattern, 4 10000 (tie),
  // 5 10000 with one 10001 per window, 6 -32768, 7 random per-window level
  task automatic run_phase(input int mode, input int len, input bit mid_rst);
    int x, ax, b, kind, rel, k, wi;
    logic [15:0] wd;
    logic [15:0] w16;
    logic signed [15:0] r16;
    bit e_bv, e_dv;
    kind = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        sums[d][i] = 0;
        bits[d][i] = 1'b0;
      end
      e_bit[d]  = 1'b0;
      e_data[d] = '0;
    end
    for (int n = 0; n < len; n++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        rel  = n - DLY[d];
        e_bv = (rel >= 50) && (rel % 50 == 0);
        e_dv = (rel >= 800) && (rel % 800 == 0);
        if (e_bv) begin
          k = rel / 50 - 1;
          bits[d][k] = (sums[d][k] > THR);
          e_bit[d]   = bits[d][k];
        end
        if (e_dv) begin
          wi = rel / 800 - 1;
          for (int i = 0; i < 16; i++) w16[15-i] = bits[d][16*wi + i];
          e_data[d] = w16;
        end
        check($sformatf("m%0d.d%0d.aligned@%0d", mode, d, n), 32'(al[d]), 32'(n >= DLY[d]));
        check($sformatf("m%0d.d%0d.bit_valid@%0d", mode, d, n), 32'(bv[d]), 32'(e_bv));
        check($sformatf("m%0d.d%0d.bit_out@%0d", mode, d, n), 32'(bo[d]), 32'(e_bit[d]));
        check($sformatf("m%0d.d%0d.data_valid@%0d", mode, d, n), 32'(dv[d]), 32'(e_dv));
        check($sformatf("m%0d.d%0d.data_out@%0d", mode, d, n), 32'(dout[d]), 32'(e_data[d]));
      end
      // Fixed anchors from the rules themselves, independent of the model.
      if (n == 800 && (mode == 0)) check("anchor.zero", 32'(dout[0]), 32'h0000);
      if (n == 800 && (mode == 1 || mode == 2 || mode == 6))
        check($sformatf("anchor.m%0d", mode), 32'(dout[0]), 32'hFFFF);
      if (mode == 3 && (n == 800 || n == 1600 || n == 2400))
        check($sformatf("anchor.word@%0d", n), 32'(dout[0]), 32'(wtab[n/800 - 1]));
      if (mode == 4 && n == 50) check("anchor.tie", 32'(bo[0]), 0);
      if (mode == 5 && n == 50) check("anchor.tie+1", 32'(bo[0]), 1);

      case (mode)
        0: x = 0;
        1: x = 20000;
        2: x = -20000;
        3: begin
          b = n / 50;
          if (b < 48) begin
            wd = wtab[b/16];
            x  = wd[15 - (b % 16)] ? 20000 : 0;
          end else x = 0;
        end
        4: x = 10000;
        5: x = (n % 50 == 17) ? 10001 : 10000;
        6: x = -32768;
        default: begin
          if (n % 50 == 0) kind = $urandom_range(0, 3);
          case (kind)
            0: x = $urandom_range(0, 4000) - 2000;
            1: x = ($urandom_range(0, 1) ? 1 : -1) * $urandom_range(19000, 21000);
            2: x = ($urandom_range(0, 1) ? 1 : -1) * $urandom_range(9990, 10010);
            default: begin
              r16 = 16'($urandom);
              x   = r16;
            end
          endcase
        end
      endcase
      rx_in = x[15:0];
      ax = (x < 0) ? -x : x;
      for (int d = 0; d < 2; d++)
        if (n >= DLY[d]) sums[d][(n - DLY[d]) / 50] += ax;

      if (mid_rst && n == 430) begin
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        break;
      end
    end
  endtask

  initial begin
    do_reset(); run_phase(0, 810, 1'b0);
    do_reset(); run_phase(1, 810, 1'b0);
    do_reset(); run_phase(2, 810, 1'b0);
    do_reset(); run_phase(3, 2410, 1'b0);
    do_reset(); run_phase(4, 810, 1'b0);
    do_reset(); run_phase(5, 810, 1'b0);
    do_reset(); run_phase(6, 810, 1'b0);
    do_reset(); run_phase(7, 500, 1'b1);
    do_reset(); run_phase(7, 1610, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
